// File: rtl/pio_in_pkg.sv
// rtl/pio_in_pkg.sv - shared constants for the PIO edge-capture input port
//
// Purpose: Avalon-MM word addresses of the register map and the EDGE_MODE
// encoding. These are shared by the RTL and by anything that drives the bus.
// Ports: none (package).
package pio_in_pkg;

  // Register map (word addresses)
  localparam logic [1:0] ADDR_DATA    = 2'd0;  // RO, synchronised inputs
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;  // RW, per-bit interrupt enable
  localparam logic [1:0] ADDR_RSVD    = 2'd2;  // reads 0, writes ignored
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;  // RO, write-1-to-clear

  // EDGE_MODE encoding
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_sync.sv
// rtl/pio_in_sync.sv - multi-stage flop synchroniser for asynchronous inputs
//
// Purpose: brings each bit of an asynchronous bus into the clk domain
// through STAGES back-to-back flops. No bus coherency is implied; each
// bit resolves independently.
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset, clears every stage
//   d        - asynchronous input bus
//   q        - last synchroniser stage
module pio_in_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pio_in_edge.sv
// rtl/pio_in_edge.sv - Avalon-MM parallel input port with edge capture and irq
//
// Purpose: synchronises DATA_W external inputs, detects edges (EDGE_MODE
// 0 rising / 1 falling / 2 any), latches them in a write-1-to-clear EDGECAP
// register and raises a level interrupt for unmasked captured edges.
// Optional feature macro: PIO_IN_IRQ_EN (IRQMASK register and irq output;
// without it IRQMASK reads 0 and irq is tied low).
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   address, chipselect  - Avalon-MM word address and slave select
//   write_n, writedata   - active-low write strobe and write data
//   in_port              - asynchronous external inputs
//   readdata             - registered read data (1 cycle latency)
//   irq                  - registered level interrupt
module pio_in_edge
  import pio_in_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [DATA_W-1:0] in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  // Capture stays disabled until the synchroniser has flushed its reset zeros,
  // so an input already high at reset release is not mistaken for an edge.
  localparam int ARM_MAX = SYNC_STAGES + 1;

  logic [DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] edge_d, edge_q;
  logic [DATA_W-1:0] edgecap_d, edgecap_q;
  logic [DATA_W-1:0] clr_mask;
  logic [DATA_W-1:0] irqmask_rd;
  logic [2:0]        arm_q, arm_d;
  logic              armed;
  logic              wr_en;
  logic [31:0]       readdata_d;
  logic              irq_d;
  logic              unused_wdata;

  pio_in_sync #(
    .WIDTH  (DATA_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;
  assign armed        = (arm_q == 3'(ARM_MAX));
  assign arm_d        = armed ? arm_q : arm_q + 3'd1;

  always_comb begin
    edge_d = '0;
    if (armed) begin
      case (EDGE_MODE)
        EDGE_RISE: edge_d = sync_q & ~prev_q;
        EDGE_FALL: edge_d = ~sync_q & prev_q;
        EDGE_ANY:  edge_d = sync_q ^ prev_q;
        default:   edge_d = '0;
      endcase
    end
  end

  // A detected edge is OR-ed in after the clear, so set wins over a
  // same-cycle write-1-to-clear of that bit.
  assign clr_mask  = (wr_en && address == ADDR_EDGECAP) ? writedata[DATA_W-1:0] : '0;
  assign edgecap_d = (edgecap_q & ~clr_mask) | edge_q;

`ifdef PIO_IN_IRQ_EN
  logic [DATA_W-1:0] irqmask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_q <= writedata[DATA_W-1:0];
    end
  end

  assign irqmask_rd = irqmask_q;
  assign irq_d      = |(edgecap_q & irqmask_q);
`else
  assign irqmask_rd = '0;
  assign irq_d      = 1'b0;
`endif

  // Read mux depends on address only; readdata is refreshed every cycle.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[DATA_W-1:0] = sync_q;
      ADDR_IRQMASK: readdata_d[DATA_W-1:0] = irqmask_rd;
      ADDR_RSVD:    readdata_d = '0;
      ADDR_EDGECAP: readdata_d[DATA_W-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      edge_q    <= '0;
      edgecap_q <= '0;
      arm_q     <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      prev_q    <= sync_q;
      edge_q    <= edge_d;
      edgecap_q <= edgecap_d;
      arm_q     <= arm_d;
      readdata  <= readdata_d;
      irq       <= irq_d;
    end
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// tb/tb_pio_in_edge.sv - directed self-checking bench for pio_in_edge
module tb_pio_in_edge;

`ifdef PIO_IN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_in_edge #(.DATA_W(8), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_rise (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_a),
    .readdata   (rd_a),
    .irq        (irq_a)
  );

  pio_in_edge #(.DATA_W(8), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_any (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_b),
    .readdata   (rd_b),
    .irq        (irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = 8'h00;
    in_b       = 8'h00;
    #1;
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'b0, irq_a}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(6);

    // DATA latency: 0x5A sampled at edge k, visible for reads at k+2
    in_a = 8'h5A;
    tick(2);                 // after k+1
    chk("data_k1", rd_a, 32'h00);
    tick();                  // after k+2
    chk("data_k2", rd_a, 32'h5A);
    address = 2'd3;
    tick();                  // after k+3: register updated this edge, read is old
    chk("edgecap_k3", rd_a, 32'h00);
    tick();
    chk("edgecap_k4", rd_a, 32'h5A);
    wr(2'd3, 32'hFF);
    tick(2);
    chk("edgecap_clr_all", rd_a, 32'h00);

    // Falling edges ignored in rising mode
    in_a = 8'h00;
    tick(5);
    chk("fall_ignored", rd_a, 32'h00);

    // Reserved address
    wr(2'd2, 32'hFFFF_FFFF);
    tick();
    chk("rsvd_reads0", rd_a, 32'h0);

    // IRQMASK write/read
    wr(2'd1, 32'h08);
    tick();
    chk("irqmask_rd", rd_a, IRQ_EN ? 32'h08 : 32'h00);

    // Bit 3 rises at edge k: EDGECAP at k+3, irq at k+4
    address = 2'd3;
    in_a    = 8'h08;
    tick(4);                 // after k+3
    chk("b3_cap_k3", rd_a, 32'h00);
    chk("b3_irq_k3", {31'b0, irq_a}, 32'h0);
    tick();                  // after k+4
    chk("b3_cap_k4", rd_a, 32'h08);
    chk("b3_irq_k4", {31'b0, irq_a}, IRQ_EN ? 32'h1 : 32'h0);
    wr(2'd3, 32'h08);        // clear at edge c
    chk("b3_irq_c", {31'b0, irq_a}, IRQ_EN ? 32'h1 : 32'h0);
    tick();                  // after c+1
    chk("b3_cap_cleared", rd_a, 32'h00);
    chk("b3_irq_cleared", {31'b0, irq_a}, 32'h0);

    // Mask all, capture bit 0
    wr(2'd1, 32'hFF);
    tick();
    chk("irqmask_ff", rd_a, IRQ_EN ? 32'hFF : 32'h00);
    address = 2'd3;
    in_a    = 8'h01;
    tick(5);
    chk("b0_cap", rd_a, 32'h01);
    chk("b0_irq", {31'b0, irq_a}, IRQ_EN ? 32'h1 : 32'h0);
    in_a = 8'h00;
    tick(5);
    chk("b0_hold", rd_a, 32'h01);
    wr(2'd3, 32'h00);
    tick();
    chk("w0_no_effect", rd_a, 32'h01);

    // Edge on bit 0 at edge k while clearing bit 0 at edge k+3: set wins
    in_a = 8'h01;
    tick(3);                 // after k+2
    wr(2'd3, 32'h01);        // edge k+3
    tick();
    chk("set_wins", rd_a, 32'h01);
    wr(2'd3, 32'h01);
    tick(2);
    chk("b0_cleared", rd_a, 32'h00);
    chk("b0_irq_low", {31'b0, irq_a}, 32'h0);

    // Inputs high through reset release produce no capture
    in_a    = 8'hFF;
    reset_n = 1'b0;
    #1;
    chk("rst_rd_async", rd_a, 32'h0);
    tick(2);
    reset_n = 1'b1;
    wr(2'd1, 32'hFF);
    address = 2'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("static_cap_%0d", i), rd_a, 32'h00);
      chk($sformatf("static_irq_%0d", i), {31'b0, irq_a}, 32'h0);
    end
    address = 2'd0;
    tick();
    chk("static_data", rd_a, 32'hFF);

    // Any-edge mode: bit 1 rise, fall, rise
    address = 2'd3;
    in_b    = 8'h02;
    tick(5);
    chk("any_rise1", rd_b, 32'h02);
    chk("any_irq", {31'b0, irq_b}, IRQ_EN ? 32'h1 : 32'h0);
    wr(2'd3, 32'h02);
    tick();
    chk("any_clr1", rd_b, 32'h00);
    in_b = 8'h00;
    tick(5);
    chk("any_fall", rd_b, 32'h02);
    wr(2'd3, 32'h02);
    tick();
    chk("any_clr2", rd_b, 32'h00);
    in_b = 8'h02;
    tick(5);
    chk("any_rise2", rd_b, 32'h02);

    // Reset pulse mid-sequence with an edge in flight
    in_b = 8'h00;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd_b, 32'h0);
    chk("mid_rst_irq", {31'b0, irq_b}, 32'h0);
    in_a = 8'h00;
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      chk($sformatf("post_rst_a_addr%0d", a), rd_a, 32'h0);
      chk($sformatf("post_rst_b_addr%0d", a), rd_b, 32'h0);
    end
    tick(4);
    chk("post_rst_b_cap", rd_b, 32'h0);
    chk("post_rst_b_irq", {31'b0, irq_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_in_edge.md
PIO_IN_EDGE -- requirements
Module: pio_in_edge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input port width (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per bit (2..4).
REQ-003 SHALL have parameter EDGE_MODE, default 0, meaning edge type: 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  DATA_W  asynchronous external inputs.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-013 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain; sync_q is the last stage.
REQ-014 SHALL use this register map: 0 DATA (RO, sync_q), 1 IRQMASK (RW, DATA_W bits), 2 reserved (reads 0, writes ignored), 3 EDGECAP (RO, write-1-to-clear).
REQ-015 SHALL register readdata every clock from address alone, with no chipselect gating; read latency is 1 cycle; bits above DATA_W read 0.
REQ-016 SHALL keep prev_q, which is sync_q delayed one cycle; edge detection per EDGE_MODE compares sync_q against prev_q.
REQ-017 SHALL set EDGECAP bit i on the clock edge after its edge is detected; in_port sampled at edge k sets the bit at edge k+SYNC_STAGES+1.
REQ-018 SHALL hold each EDGECAP bit set until it is cleared by writing 1 to it; writing 0 has no effect.
REQ-019 SHALL let set win over clear when an edge on bit i and a clear of bit i occur in the same cycle.
REQ-020 SHALL capture an edge that occurs while EDGECAP bit i is already set, with no overflow indication.
REQ-021 SHALL drive irq on the next clock as the OR over all bits of (EDGECAP AND IRQMASK).
REQ-022 SHALL include an arm counter: edge capture is suppressed for SYNC_STAGES+1 cycles after reset release, so inputs static at reset produce no spurious edge.
REQ-023 SHALL update IRQMASK on a write (chipselect=1, write_n=0, address=1), visible to reads from the following cycle.

Reset
REQ-024 SHALL asynchronously clear readdata, irq, sync chain, prev_q, EDGECAP, IRQMASK and the arm counter on reset_n low.
REQ-025 SHALL discard captured edges and the mask on reset asserted mid-operation; after release, REQ-022 applies.

Configuration
REQ-026 SHALL support macro PIO_IN_IRQ_EN: when defined, IRQMASK and irq behave per REQ-021/023; when undefined, IRQMASK reads 0, writes to it are ignored, irq is tied 0, and EDGECAP remains functional.

Structure
REQ-027 SHALL place address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and the EDGE_MODE encoding constants in package pio_in_pkg.
REQ-028 SHALL implement the synchronizer as sub-module pio_in_sync (parameters WIDTH and STAGES, asynchronous reset).

Verification
REQ-029 SHALL cover: DATA_W=8, SYNC_STAGES=2, in_port 0x00->0x5A at edge k -> DATA read returns 0x5A only from reads issued at edge k+2 or later.
REQ-030 SHALL cover: EDGE_MODE=0, bit 3 rises -> EDGECAP=0x08 at edge k+3; IRQMASK=0x08 -> irq=1 one cycle later; write 0x08 to address 3 -> EDGECAP=0, irq=0 next cycle.
REQ-031 SHALL cover: same-cycle rising edge on bit 0 and write-1-clear of bit 0 -> EDGECAP bit 0 stays 1.
REQ-032 SHALL cover: in_port=0xFF held through reset release -> EDGECAP stays 0x00 and irq stays 0 for 20 cycles.
REQ-033 SHALL cover: EDGE_MODE=2, bit 1 toggles 1->0->1 -> bit 1 set after each transition; reset_n pulsed low mid-sequence -> all registers read 0.
REQ-034 SHALL cover: build without PIO_IN_IRQ_EN, write 0xFF to IRQMASK then edge on bit 0 -> IRQMASK reads 0, irq stays 0, EDGECAP=0x01.
